// File: rtl/glyph_pointer_sequencer.sv
// glyph_pointer_sequencer
//
// Turns a request of NUM_CHARS packed 4-bit glyph codes plus one glyph row
// into a stream of ROM row pointers, one beat per character, with a
// valid/ready handshake towards the ROM reader.
//
// Code map: 0-9 digits (chip select 01), 10/11 AM/PM (10), 13/14 red/green
// colour labels (11), 12/15 blank. A beat whose row falls outside the
// glyph height is also blank (addr 0, cs 00).
//
// Ports
//   clk       : clock
//   reset     : synchronous, active-high reset
//   start     : request strobe, only looked at while idle
//   codes     : packed glyph codes, char 0 in bits [3:0]
//   row       : glyph row to fetch for this request
//   out_addr  : ROM row address (glyph base + row)
//   out_cs    : ROM chip select (00 blank, 01 digits, 10 AM/PM, 11 colour)
//   out_idx   : character index of the current beat
//   out_valid : beat valid
//   out_ready : downstream accepts the beat
//   busy      : request in progress (EMIT or DONE)
//   done      : one-cycle pulse when a request finishes
module glyph_pointer_sequencer #(
    parameter int NUM_CHARS    = 8,
    parameter int DIGIT_STRIDE = 60,
    parameter int DIGIT_H      = 60,
    parameter int LABEL_STRIDE = 20,
    parameter int LABEL_H      = 20,
    parameter int ADDR_W       = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [4*NUM_CHARS-1:0]       codes,
    input  logic [ADDR_W-1:0]            row,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [1:0]                   out_cs,
    output logic [$clog2(NUM_CHARS)-1:0] out_idx,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done
);

    localparam int IDX_W = $clog2(NUM_CHARS);

    localparam logic [ADDR_W-1:0] DSTR = ADDR_W'(DIGIT_STRIDE);
    localparam logic [ADDR_W-1:0] DLIM = ADDR_W'(DIGIT_H);
    localparam logic [ADDR_W-1:0] LSTR = ADDR_W'(LABEL_STRIDE);
    localparam logic [ADDR_W-1:0] LLIM = ADDR_W'(LABEL_H);
    localparam logic [IDX_W-1:0]  LAST = IDX_W'(NUM_CHARS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state, state_d;
    logic [4*NUM_CHARS-1:0]   codes_q, codes_d;
    logic [ADDR_W-1:0]        row_q, row_d;
    logic [ADDR_W-1:0]        addr_d;
    logic [1:0]               cs_d;
    logic [IDX_W-1:0]         idx_d;
    logic                     valid_d;

    logic [IDX_W-1:0]         next_idx;
    logic [3:0]               sel_code;
    logic [ADDR_W-1:0]        sel_row;
    logic [ADDR_W+1:0]        beat;

    // Map one code and row to {cs, addr}; anything blank or out of the
    // glyph's height collapses to all zeros.
    function automatic logic [ADDR_W+1:0] map_beat(input logic [3:0]        code,
                                                   input logic [ADDR_W-1:0] r);
        logic [ADDR_W-1:0] base;
        logic [1:0]        cs;
        logic              in_range;
        base     = '0;
        cs       = 2'b00;
        in_range = 1'b0;
        case (code)
            4'd10:       begin base = '0;   cs = 2'b10; end
            4'd11:       begin base = LSTR; cs = 2'b10; end
            4'd13:       begin base = '0;   cs = 2'b11; end
            4'd14:       begin base = LSTR; cs = 2'b11; end
            4'd12, 4'd15: begin base = '0;  cs = 2'b00; end
            default:     begin base = ADDR_W'(code) * DSTR; cs = 2'b01; end
        endcase
        if (cs == 2'b01) in_range = (r < DLIM);
        else             in_range = (r < LLIM);
        if (cs == 2'b00 || !in_range) return '0;
        return {cs, base + r};
    endfunction

    // The beat being loaded is either char 0 straight from the inputs (on
    // acceptance) or the next latched char (on an EMIT handshake).
    assign next_idx = out_idx + IDX_W'(1);

    always_comb begin
        sel_code = codes[3:0];
        sel_row  = row;
        if (state != IDLE) begin
            sel_row = row_q;
            for (int i = 0; i < NUM_CHARS; i++) begin
                if (IDX_W'(i) == next_idx) sel_code = codes_q[4*i +: 4];
            end
        end
    end

    assign beat = map_beat(sel_code, sel_row);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            codes_q   <= '0;
            row_q     <= '0;
            out_addr  <= '0;
            out_cs    <= 2'b00;
            out_idx   <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            codes_q   <= codes_d;
            row_q     <= row_d;
            out_addr  <= addr_d;
            out_cs    <= cs_d;
            out_idx   <= idx_d;
            out_valid <= valid_d;
        end
    end

    // Outputs only move on acceptance or on a handshake, so they hold
    // steady automatically under backpressure.
    always_comb begin
        state_d = state;
        codes_d = codes_q;
        row_d   = row_q;
        addr_d  = out_addr;
        cs_d    = out_cs;
        idx_d   = out_idx;
        valid_d = out_valid;
        case (state)
            IDLE: begin
                if (start) begin
                    codes_d = codes;
                    row_d   = row;
                    idx_d   = '0;
                    cs_d    = beat[ADDR_W+1:ADDR_W];
                    addr_d  = beat[ADDR_W-1:0];
                    valid_d = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_valid && out_ready) begin
                    if (out_idx == LAST) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        idx_d  = next_idx;
                        cs_d   = beat[ADDR_W+1:ADDR_W];
                        addr_d = beat[ADDR_W-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_glyph_pointer_sequencer.sv
// tb_glyph_pointer_sequencer
//
// Directed bench for glyph_pointer_sequencer with NUM_CHARS=4 and default
// strides/heights. A table of requests with hand-computed beats is run
// under continuous ready, followed by hand-written sequences for
// back-to-back starts, backpressure, start while busy and mid-request reset.
module tb_glyph_pointer_sequencer;

    localparam int NC = 4;
    localparam int AW = 10;

    logic          clk;
    logic          reset;
    logic          start;
    logic [4*NC-1:0] codes;
    logic [AW-1:0] row;
    logic [AW-1:0] out_addr;
    logic [1:0]    out_cs;
    logic [1:0]    out_idx;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    int nVectors;
    int nMiscompares;

    typedef struct {
        logic [15:0]         codes;
        logic [9:0]          row;
        logic [3:0][9:0]     addr;
        logic [3:0][1:0]     cs;
    } vec_t;

    vec_t vecs[7];

    glyph_pointer_sequencer #(
        .NUM_CHARS(NC),
        .DIGIT_STRIDE(60),
        .DIGIT_H(60),
        .LABEL_STRIDE(20),
        .LABEL_H(20),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .codes(codes),
        .row(row),
        .out_addr(out_addr),
        .out_cs(out_cs),
        .out_idx(out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something upstream stalls forever.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input int i, input logic [15:0] c, input logic [9:0] r,
                          input logic [9:0] a0, input logic [1:0] c0,
                          input logic [9:0] a1, input logic [1:0] c1,
                          input logic [9:0] a2, input logic [1:0] c2,
                          input logic [9:0] a3, input logic [1:0] c3);
        vecs[i].codes   = c;
        vecs[i].row     = r;
        vecs[i].addr[0] = a0; vecs[i].cs[0] = c0;
        vecs[i].addr[1] = a1; vecs[i].cs[1] = c1;
        vecs[i].addr[2] = a2; vecs[i].cs[2] = c2;
        vecs[i].addr[3] = a3; vecs[i].cs[3] = c3;
    endtask

    task automatic applyStimulus(input logic s, input logic [15:0] c,
                                 input logic [9:0] r, input logic rdy);
        start     = s;
        codes     = c;
        row       = r;
        out_ready = rdy;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        nVectors++;
        if (actual != expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkBeat(input string tag, input int v, input int b);
        checkOutput({tag, " valid"}, int'(out_valid), 1);
        checkOutput({tag, " idx"},   int'(out_idx), b);
        checkOutput({tag, " addr"},  int'(out_addr), int'(vecs[v].addr[b]));
        checkOutput({tag, " cs"},    int'(out_cs), int'(vecs[v].cs[b]));
        checkOutput({tag, " busy"},  int'(busy), 1);
        checkOutput({tag, " done"},  int'(done), 0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " valid"}, int'(out_valid), 0);
        checkOutput({tag, " busy"},  int'(busy), 0);
        checkOutput({tag, " done"},  int'(done), 0);
    endtask

    // Runs one full request under continuous ready, starting from an idle
    // negedge; input codes/row are scrambled after acceptance.
    task automatic runVector(input int v);
        string tag;
        applyStimulus(1'b1, vecs[v].codes, vecs[v].row, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, ~vecs[v].codes, vecs[v].row + 10'd3, 1'b1);
        for (int b = 0; b < NC; b++) begin
            tag = $sformatf("vec%0d beat%0d", v, b);
            checkBeat(tag, v, b);
            @(negedge clk);
        end
        tag = $sformatf("vec%0d donecyc", v);
        checkOutput({tag, " done"},  int'(done), 1);
        checkOutput({tag, " valid"}, int'(out_valid), 0);
        checkOutput({tag, " busy"},  int'(busy), 1);
        @(negedge clk);
        checkIdle($sformatf("vec%0d after", v));
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;

        addVec(0, 16'h390B, 10'd5,  10'd25, 2'b10, 10'd5,  2'b01, 10'd545, 2'b01, 10'd185, 2'b01);
        addVec(1, 16'hFCED, 10'd7,  10'd7,  2'b11, 10'd27, 2'b11, 10'd0,   2'b00, 10'd0,   2'b00);
        addVec(2, 16'h9EA2, 10'd30, 10'd150,2'b01, 10'd0,  2'b00, 10'd0,   2'b00, 10'd570, 2'b01);
        addVec(3, 16'h0BDA, 10'd19, 10'd19, 2'b10, 10'd19, 2'b11, 10'd39,  2'b10, 10'd19,  2'b01);
        addVec(4, 16'h1E9A, 10'd20, 10'd0,  2'b00, 10'd560,2'b01, 10'd0,   2'b00, 10'd80,  2'b01);
        addVec(5, 16'hCB09, 10'd60, 10'd0,  2'b00, 10'd0,  2'b00, 10'd0,   2'b00, 10'd0,   2'b00);
        addVec(6, 16'h50B9, 10'd59, 10'd599,2'b01, 10'd0,  2'b00, 10'd59,  2'b01, 10'd359, 2'b01);

        // Reset with start and ready asserted: reset must win.
        reset = 1'b1;
        applyStimulus(1'b1, 16'h390B, 10'd5, 1'b1);
        repeat (2) @(negedge clk);
        checkIdle("reset");
        checkOutput("reset addr", int'(out_addr), 0);
        checkOutput("reset cs",   int'(out_cs), 0);
        checkOutput("reset idx",  int'(out_idx), 0);
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0, 10'd0, 1'b0);
        @(negedge clk);
        checkIdle("post reset");

        for (int v = 0; v < 7; v++) runVector(v);

        // Start held through DONE is ignored there, taken in the following IDLE.
        applyStimulus(1'b1, vecs[0].codes, vecs[0].row, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, vecs[0].codes, vecs[0].row, 1'b1);
        for (int b = 0; b < NC; b++) begin
            checkBeat($sformatf("b2b first beat%0d", b), 0, b);
            @(negedge clk);
        end
        checkOutput("b2b done", int'(done), 1);
        applyStimulus(1'b1, vecs[1].codes, vecs[1].row, 1'b1);
        @(negedge clk);
        checkIdle("b2b gap");
        @(negedge clk);
        applyStimulus(1'b0, 16'h0, 10'd0, 1'b1);
        for (int b = 0; b < NC; b++) begin
            checkBeat($sformatf("b2b second beat%0d", b), 1, b);
            @(negedge clk);
        end
        checkOutput("b2b second done", int'(done), 1);
        @(negedge clk);

        // Backpressure: ready low for three cycles while beat 1 is shown.
        applyStimulus(1'b1, vecs[0].codes, vecs[0].row, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, vecs[0].codes, vecs[0].row, 1'b1);
        checkBeat("bp beat0", 0, 0);
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkBeat($sformatf("bp hold%0d", k), 0, 1);
            if (k == 3) out_ready = 1'b1;
            @(negedge clk);
        end
        checkBeat("bp beat2", 0, 2);
        @(negedge clk);
        checkBeat("bp beat3", 0, 3);
        @(negedge clk);
        checkOutput("bp done", int'(done), 1);
        @(negedge clk);
        checkIdle("bp after");

        // Start with different codes during EMIT must be ignored.
        applyStimulus(1'b1, vecs[3].codes, vecs[3].row, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, vecs[3].codes, vecs[3].row, 1'b1);
        checkBeat("busy start beat0", 3, 0);
        @(negedge clk);
        checkBeat("busy start beat1", 3, 1);
        applyStimulus(1'b1, vecs[1].codes, vecs[1].row, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, vecs[2].codes, vecs[2].row, 1'b1);
        checkBeat("busy start beat2", 3, 2);
        @(negedge clk);
        checkBeat("busy start beat3", 3, 3);
        @(negedge clk);
        checkOutput("busy start done", int'(done), 1);
        @(negedge clk);
        checkIdle("busy start after");

        // Reset on beat 2 abandons the request; next start begins at idx 0.
        applyStimulus(1'b1, vecs[0].codes, vecs[0].row, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, vecs[0].codes, vecs[0].row, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkBeat("rst beat2", 0, 2);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checkIdle("rst cut");
        checkOutput("rst cut addr", int'(out_addr), 0);
        checkOutput("rst cut cs",   int'(out_cs), 0);
        checkOutput("rst cut idx",  int'(out_idx), 0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkIdle("rst no done");
        runVector(1);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
